// File: rtl/sd_spi_card_responder.sv
// SD card emulator on the SPI bus: answers the init sequence (CMD0/8/55/41/58/16)
// and streams one 512-byte block per CMD17 from an external byte source.
module sd_spi_card_responder #(
  parameter int unsigned INIT_POLLS = 3,
  parameter logic [31:0] OCR        = 32'hC0FF8000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        spi_ssn,
  input  logic        spi_sck,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic [31:0] blk_addr,
  output logic [8:0]  byte_idx,
  input  logic [7:0]  rd_byte,
  output logic        card_ready,
  output logic        cmd_strobe,
  output logic [5:0]  cmd_index
);

  typedef enum logic [2:0] {
    StIdle, StCmd, StNcr, StResp, StNac, StToken, StData, StCrc
  } state_e;

  state_e      state_q;
  logic [1:0]  ssn_s, sck_s, mosi_s;
  logic        sck_q;
  logic [2:0]  bit_cnt;
  logic [6:0]  rx_q;
  logic [7:0]  tx_q;
  logic [39:0] frame_q;
  logic [2:0]  cnt_q;
  logic [39:0] resp_q;
  logic        data_pend;
  logic        app_q;
  logic [31:0] polls_q;

  logic        sck_rise, sck_fall, active;
  logic [7:0]  rx_byte;
  logic        idle, legal, ready_n, pend_n, app_n, latch_addr;
  logic [7:0]  r1;
  logic [31:0] ext, polls_n;
  logic [2:0]  len_n;
  logic [39:0] resp_n;

  assign sck_rise = sck_s[1] & ~sck_q;
  assign sck_fall = ~sck_s[1] & sck_q;
  assign active   = ~ssn_s[1];
  assign rx_byte  = {rx_q, mosi_s[1]};

  // Command decode; only meaningful on the boundary that completes the 6th frame byte,
  // where {frame_q, rx_byte} is the whole 48-bit frame.
  always_comb begin
    idle       = ~card_ready;
    legal      = (frame_q[39:38] == 2'b01) && rx_byte[0];
    r1         = {5'b0, 1'b1, 1'b0, idle};
    ext        = 32'hFFFF_FFFF;
    len_n      = 3'd1;
    ready_n    = card_ready;
    polls_n    = polls_q;
    pend_n     = 1'b0;
    app_n      = legal && (frame_q[37:32] == 6'd55);
    latch_addr = legal && (frame_q[37:32] == 6'd17);
    if (legal) begin
      case (frame_q[37:32])
        6'd0: begin
          r1      = 8'h01;
          ready_n = 1'b0;
          polls_n = '0;
        end
        6'd8: begin
          r1    = {7'b0, idle};
          ext   = {24'h000001, frame_q[7:0]};
          len_n = 3'd5;
        end
        6'd55, 6'd16: r1 = {7'b0, idle};
        6'd41: begin
          if (app_q) begin
            if (polls_q < INIT_POLLS) begin
              r1      = 8'h01;
              polls_n = polls_q + 32'd1;
            end else begin
              r1      = 8'h00;
              ready_n = 1'b1;
            end
          end
        end
        6'd58: begin
          r1    = {7'b0, idle};
          ext   = OCR;
          len_n = 3'd5;
        end
        6'd17: begin
          if (card_ready) begin
            r1     = 8'h00;
            pend_n = 1'b1;
          end
        end
        default: ;
      endcase
    end
    resp_n = {r1, ext};
  end

  // The state names the byte currently on MISO; each byte boundary picks the next one.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= StIdle;
      ssn_s      <= 2'b11;
      sck_s      <= 2'b00;
      mosi_s     <= 2'b11;
      sck_q      <= 1'b0;
      bit_cnt    <= '0;
      rx_q       <= '0;
      tx_q       <= 8'hFF;
      frame_q    <= '0;
      cnt_q      <= '0;
      resp_q     <= '1;
      data_pend  <= 1'b0;
      app_q      <= 1'b0;
      polls_q    <= '0;
      spi_miso   <= 1'b1;
      blk_addr   <= '0;
      byte_idx   <= '0;
      card_ready <= 1'b0;
      cmd_strobe <= 1'b0;
      cmd_index  <= '0;
    end else begin
      ssn_s      <= {ssn_s[0], spi_ssn};
      sck_s      <= {sck_s[0], spi_sck};
      mosi_s     <= {mosi_s[0], spi_mosi};
      sck_q      <= sck_s[1];
      cmd_strobe <= 1'b0;
      if (!active) begin
        state_q  <= StIdle;
        bit_cnt  <= '0;
        tx_q     <= 8'hFF;
        spi_miso <= 1'b1;
        app_q    <= 1'b0;
      end else begin
        if (sck_fall) begin
          spi_miso <= tx_q[7];
          tx_q     <= {tx_q[6:0], 1'b1};
        end
        if (sck_rise) begin
          bit_cnt <= bit_cnt + 3'd1;
          rx_q    <= rx_byte[6:0];
          if (bit_cnt == 3'd7) begin
            tx_q <= 8'hFF;
            case (state_q)
              StIdle: begin
                if (!rx_byte[7]) begin
                  state_q <= StCmd;
                  frame_q <= {32'b0, rx_byte};
                  cnt_q   <= 3'd1;
                end
              end
              StCmd: begin
                if (cnt_q == 3'd5) begin
                  state_q    <= StNcr;
                  cmd_strobe <= 1'b1;
                  cmd_index  <= frame_q[37:32];
                  card_ready <= ready_n;
                  polls_q    <= polls_n;
                  app_q      <= app_n;
                  data_pend  <= pend_n;
                  resp_q     <= resp_n;
                  cnt_q      <= len_n;
                  if (latch_addr) blk_addr <= frame_q[31:0];
                end else begin
                  frame_q <= {frame_q[31:0], rx_byte};
                  cnt_q   <= cnt_q + 3'd1;
                end
              end
              StNcr, StResp: begin
                if (cnt_q != 3'd0) begin
                  state_q <= StResp;
                  tx_q    <= resp_q[39:32];
                  resp_q  <= {resp_q[31:0], 8'hFF};
                  cnt_q   <= cnt_q - 3'd1;
                end else begin
                  state_q <= data_pend ? StNac : StIdle;
                end
              end
              StNac: begin
                state_q  <= StToken;
                tx_q     <= 8'hFE;
                byte_idx <= '0;
              end
              StToken, StData: begin
                // byte_idx wraps to 0 once all 512 bytes have been loaded.
                if (state_q == StData && byte_idx == 9'd0) begin
                  state_q <= StCrc;
                  cnt_q   <= 3'd1;
                end else begin
                  state_q  <= StData;
                  tx_q     <= rd_byte;
                  byte_idx <= byte_idx + 9'd1;
                end
              end
              StCrc: begin
                if (cnt_q != 3'd0) cnt_q <= 3'd0;
                else state_q <= StIdle;
              end
              default: state_q <= StIdle;
            endcase
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_sd_spi_card_responder.sv
// Drives SPI mode-0 command sequences into the card responder and compares every
// response byte against a per-command model of the card's behaviour.
module tb_sd_spi_card_responder;

  localparam int HALF = 4;
  localparam int POLLS = 3;

  logic        clk = 1'b0;
  logic        rstn;
  logic        spi_ssn, spi_sck, spi_mosi;
  logic        spi_miso;
  logic [31:0] blk_addr;
  logic [8:0]  byte_idx;
  logic [7:0]  rd_byte = 8'h00;
  logic        card_ready, cmd_strobe;
  logic [5:0]  cmd_index;

  logic [7:0]  key_q = 8'h00;
  int          strobe_cnt = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  logic [7:0]  exp_q[$];
  bit          m_ready = 1'b0;
  bit          m_app = 1'b0;
  int          m_polls = 0;

  sd_spi_card_responder #(.INIT_POLLS(POLLS), .OCR(32'hC0FF8000)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .spi_ssn    (spi_ssn),
    .spi_sck    (spi_sck),
    .spi_mosi   (spi_mosi),
    .spi_miso   (spi_miso),
    .blk_addr   (blk_addr),
    .byte_idx   (byte_idx),
    .rd_byte    (rd_byte),
    .card_ready (card_ready),
    .cmd_strobe (cmd_strobe),
    .cmd_index  (cmd_index)
  );

  always #5 clk = ~clk;

  // Block storage stand-in: byte k of any block is k ^ key, one clk of latency.
  always @(posedge clk) rd_byte <= byte_idx[7:0] ^ key_q;
  always @(posedge clk) if (cmd_strobe === 1'b1) strobe_cnt <= strobe_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = tx[7-i];
      repeat (HALF) @(negedge clk);
      spi_sck = 1'b1;
      rx = {rx[6:0], spi_miso};
      repeat (HALF) @(negedge clk);
      spi_sck = 1'b0;
    end
  endtask

  // Card behaviour: what the host should read back after a command frame.
  task automatic model_cmd(input logic [5:0] idx, input logic [31:0] arg, input bit legal,
                           input logic [7:0] key);
    logic [7:0] idle, ill, r1;
    bit         data, set_app;
    idle = {7'b0, !m_ready};
    ill  = idle | 8'h04;
    r1   = ill;
    data = 1'b0;
    set_app = 1'b0;
    exp_q.delete();
    exp_q.push_back(8'hFF);
    if (legal) begin
      if (idx == 0) begin
        m_ready = 1'b0; m_polls = 0; r1 = 8'h01;
      end else if (idx == 8 || idx == 16 || idx == 55 || idx == 58) begin
        r1 = idle;
        set_app = (idx == 55);
      end else if (idx == 41 && m_app) begin
        if (m_polls < POLLS) begin
          m_polls++; r1 = 8'h01;
        end else begin
          m_ready = 1'b1; r1 = 8'h00;
        end
      end else if (idx == 17 && m_ready) begin
        r1 = 8'h00; data = 1'b1;
      end
    end
    m_app = set_app;
    exp_q.push_back(r1);
    if (legal && idx == 8) begin
      exp_q.push_back(8'h00); exp_q.push_back(8'h00);
      exp_q.push_back(8'h01); exp_q.push_back(arg[7:0]);
    end
    if (legal && idx == 58) begin
      exp_q.push_back(8'hC0); exp_q.push_back(8'hFF);
      exp_q.push_back(8'h80); exp_q.push_back(8'h00);
    end
    if (data) begin
      exp_q.push_back(8'hFF);
      exp_q.push_back(8'hFE);
      for (int k = 0; k < 512; k++) exp_q.push_back(8'(k % 256) ^ key);
      exp_q.push_back(8'hFF);
      exp_q.push_back(8'hFF);
    end
    exp_q.push_back(8'hFF);
  endtask

  // abort_at >= 0: after that many response bytes, clock 3 bits and drop chip select.
  task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg, input bit endbit,
                         input int abort_at);
    logic [47:0] frame;
    logic [7:0]  rx;
    int          s0;
    frame = {2'b01, idx, arg, 7'h4A, endbit};
    s0 = strobe_cnt;
    for (int b = 0; b < 6; b++) xfer(frame[47-8*b -: 8], 8, rx);
    model_cmd(idx, arg, endbit, key_q);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (abort_at >= 0 && i == abort_at) begin
        xfer(8'hFF, 3, rx);
        spi_ssn = 1'b1;
        m_app = 1'b0;
        break;
      end
      xfer(8'hFF, 8, rx);
      chk($sformatf("cmd%0d resp byte %0d", idx, i), {24'b0, rx}, {24'b0, exp_q[i]});
      if (i == 0) begin
        chk($sformatf("cmd%0d strobe count", idx), strobe_cnt - s0, 1);
        chk($sformatf("cmd%0d index", idx), {26'b0, cmd_index}, {26'b0, idx});
      end
    end
    chk($sformatf("cmd%0d card_ready", idx), {31'b0, card_ready}, {31'b0, m_ready});
  endtask

  initial begin
    logic [7:0]  rx;
    logic [5:0]  unk;
    logic [31:0] addr;

    rstn = 1'b0;
    spi_ssn = 1'b1;
    spi_sck = 1'b0;
    spi_mosi = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset miso", {31'b0, spi_miso}, 1);
    chk("reset card_ready", {31'b0, card_ready}, 0);
    chk("reset cmd_strobe", {31'b0, cmd_strobe}, 0);
    chk("reset cmd_index", {26'b0, cmd_index}, 0);
    chk("reset blk_addr", blk_addr, 0);
    chk("reset byte_idx", {23'b0, byte_idx}, 0);
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    spi_ssn = 1'b0;
    repeat (4) @(negedge clk);

    for (int i = 0; i < 2; i++) begin
      xfer(8'hFF, 8, rx);
      chk("idle filler", {24'b0, rx}, 32'hFF);
    end

    run_cmd(6'd17, $urandom, 1'b1, -1);
    run_cmd(6'd0, 32'h0, 1'b1, -1);
    run_cmd(6'd8, 32'h0000_01AA, 1'b1, -1);
    run_cmd(6'd8, {$urandom_range(0, 16777215), 8'($urandom)}, 1'b1, -1);

    unk = 6'd0;
    for (int t = 0; t < 64; t++) begin
      unk = 6'($urandom_range(1, 63));
      if (!(unk inside {6'd8, 6'd16, 6'd17, 6'd41, 6'd55, 6'd58})) break;
    end
    if (unk inside {6'd8, 6'd16, 6'd17, 6'd41, 6'd55, 6'd58}) unk = 6'd13;
    run_cmd(unk, $urandom, 1'b1, -1);
    run_cmd(6'd0, $urandom, 1'b0, -1);
    run_cmd(6'd41, 32'h4000_0000, 1'b1, -1);

    for (int p = 0; p < 4; p++) begin
      run_cmd(6'd55, 32'h0, 1'b1, -1);
      run_cmd(6'd41, 32'h4000_0000, 1'b1, -1);
    end
    run_cmd(6'd58, 32'h0, 1'b1, -1);
    run_cmd(6'd16, 32'h0000_0200, 1'b1, -1);

    key_q = 8'h00;
    run_cmd(6'd17, 32'h0000_0010, 1'b1, -1);
    chk("read blk_addr", blk_addr, 32'h0000_0010);

    key_q = 8'($urandom);
    addr = $urandom;
    run_cmd(6'd17, addr, 1'b1, 104);
    repeat (4) @(negedge clk);
    chk("abort miso", {31'b0, spi_miso}, 1);
    chk("abort card_ready kept", {31'b0, card_ready}, 1);
    chk("abort blk_addr", blk_addr, addr);
    spi_ssn = 1'b0;
    repeat (4) @(negedge clk);
    run_cmd(6'd0, 32'h0, 1'b1, -1);
    run_cmd(6'd55, 32'h0, 1'b1, -1);
    run_cmd(6'd41, 32'h4000_0000, 1'b1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sd_spi_card_responder.md
SD_SPI_CARD_RESPONDER -- requirements
Module: sd_spi_card_responder

Interface
REQ-001 SHALL have parameter INIT_POLLS, default 3, number of ACMD41 answers returning 0x01 before 0x00.
REQ-002 SHALL have parameter OCR, default 32'hC0FF8000, OCR word returned by CMD58 (CCS=1, SDHC block addressing).
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 rstn  input  1  asynchronous active-low reset.
REQ-005 spi_ssn  input  1  chip select from host, active low.
REQ-006 spi_sck  input  1  SPI clock from host, mode 0.
REQ-007 spi_mosi  input  1  command bits from host.
REQ-008 spi_miso  output  1  response/data bits to host.
REQ-009 blk_addr  output  32  block address of current CMD17 (argument verbatim).
REQ-010 byte_idx  output  9  offset of data byte being fetched, 0..511.
REQ-011 rd_byte  input  8  data byte for {blk_addr, byte_idx}; sampled 2 clk after byte_idx changes.
REQ-012 card_ready  output  1  1 once ACMD41 has returned 0x00.
REQ-013 cmd_strobe  output  1  one-clk pulse per complete command frame.
REQ-014 cmd_index  output  6  index of last complete command.

Function
REQ-015 spi_ssn/sck/mosi SHALL pass 2-flop synchronizers; sck edges detected in clk domain; host SCK high and low phases >= 4 clk each.
REQ-016 MOSI SHALL be sampled on synchronized sck rising edge; spi_miso updated only on sck falling edge (or ssn deassert).
REQ-017 A bit counter SHALL reset on ssn falling; bytes are 8 rising edges; all parsing and response on these byte boundaries.
REQ-018 States: IDLE, CMD, NCR, RESP, NAC, TOKEN, DATA, CRC.
REQ-019 IDLE: byte whose first bit is 0 starts CMD; bytes 0xFF ignored; miso=1.
REQ-020 CMD: collect 48 bits {01, index[5:0], arg[31:0], crc7, end}; CRC not checked; frame with bits[47:46]!=01 or end bit 0 treated as illegal (R1 |= 0x04).
REQ-021 After frame: cmd_strobe pulses, cmd_index updates; one 0xFF byte (NCR) then RESP bytes MSB first.
REQ-022 R1 bit0 = idle flag (=~card_ready); bit2 = illegal command.
REQ-023 CMD0: idle flag set, card_ready=0, ACMD41 poll count cleared, R1=0x01.
REQ-024 CMD8: R7 = R1, 0x00, 0x00, 0x01, arg[7:0].
REQ-025 CMD55: R1, sets app flag for next command only.
REQ-026 CMD41 with app flag: R1=0x01 for first INIT_POLLS, then 0x00 and card_ready=1 (saturating).
REQ-027 CMD58: R3 = R1, OCR[31:24..7:0].
REQ-028 CMD16: R1 only.
REQ-029 CMD17 when card_ready: R1=0x00, one 0xFF (NAC), 0xFE token, 512 bytes rd_byte, 0xFF 0xFF CRC, then IDLE.
REQ-030 CMD17 when not ready: R1=0x05, no data.
REQ-031 Any other index, or CMD41 without app flag: R1 = idle|0x04.
REQ-032 blk_addr latched on CMD17 frame end; byte_idx=0 at token start, increments after each data byte loaded; fetched byte latched before its first falling edge.
REQ-033 MOSI ignored from NCR through CRC; no command accepted mid-response.
REQ-034 spi_ssn high at any time: return to IDLE within 3 clk, miso=1, app flag cleared, card_ready/idle kept.

Reset
REQ-035 rstn low: state IDLE, spi_miso=1, card_ready=0, idle flag=1, app flag=0, poll count=0, cmd_strobe=0, cmd_index=0, blk_addr=0, byte_idx=0.
REQ-036 Reset release takes effect immediately; first command may follow on next ssn assertion.

Verification
REQ-037 CMD0 (40 00 00 00 00 95) -> after one 0xFF, R1=0x01; cmd_index=0, cmd_strobe one pulse.
REQ-038 CMD8 arg 0x000001AA -> 0x01 00 00 01 AA.
REQ-039 INIT_POLLS=3: CMD55+ACMD41 x4 -> 0x01,0x01,0x01,0x00; card_ready=1 after 4th; CMD58 -> 0x00 C0 FF 80 00.
REQ-040 CMD17 arg 0x00000010 after init, rd_byte=byte_idx[7:0] -> 0x00, 0xFF, 0xFE, 00..FF,00..FF, FF FF; blk_addr=0x10.
REQ-041 CMD17 before init -> R1=0x05, following bytes 0xFF.
REQ-042 ssn raised at data byte 100 -> miso=1, IDLE; next CMD0 answered 0x01 with card_ready cleared.
